ipg_xgmii_tx_insert: RTL and testbench

- TX-side counterpart of the RX IPG extraction path that produces rx_ipg_data.
- Sits between the 10G MAC XGMII TX output and the PHY XGMII TX input, all in the tx_clk domain.
- Accepts 56-bit IPG payload words on a valid/ready stream, buffers them, and substitutes each into an eligible all-idle XGMII word as an IPG-marked block.
- Frames and all other XGMII traffic pass through with fixed 1-cycle latency.

---
 rtl/ipg_pkg.sv | 14 +
 rtl/ipg_sync_fifo.sv | 53 +++++
 rtl/ipg_xgmii_tx_insert.sv | 81 ++++++++
 tb/tb_ipg_xgmii_tx_insert.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ipg_pkg.sv
// rtl/ipg_pkg.sv - shared XGMII idle constants for the TX IPG inserter and RX IPG extractor
package ipg_pkg;

  localparam logic [7:0]  XGMII_IDLE       = 8'h07;
  localparam logic [63:0] XGMII_IDLE_WORD  = {8{XGMII_IDLE}};
  localparam logic [7:0]  IPG_MARK_DEFAULT = 8'h5C;
  localparam int          IPG_PAYLOAD_W    = 56;

  // Only a fully idle word qualifies; control words carrying FE/9C etc. do not.
  function automatic logic is_idle_word(input logic [63:0] txd, input logic [7:0] txc);
    return (txc == 8'hFF) && (txd == XGMII_IDLE_WORD);
  endfunction

endpackage

// File: rtl/ipg_sync_fifo.sv
// rtl/ipg_sync_fifo.sv - single-clock payload FIFO, power-of-2 depth, level output
module ipg_sync_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; pointers and level alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ipg_xgmii_tx_insert.sv
// rtl/ipg_xgmii_tx_insert.sv - substitutes buffered IPG payload into guarded all-idle XGMII TX words
module ipg_xgmii_tx_insert
  import ipg_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         GUARD_WORDS = 1,
  parameter logic [7:0] IPG_MARK    = IPG_MARK_DEFAULT
) (
  input  logic                          tx_clk,
  input  logic                          tx_rst_n,
  input  logic [63:0]                   xgmii_txd_in,
  input  logic [7:0]                    xgmii_txc_in,
  output logic [63:0]                   xgmii_txd_out,
  output logic [7:0]                    xgmii_txc_out,
  input  logic [IPG_PAYLOAD_W-1:0]      s_ipg_tdata,
  input  logic                          s_ipg_tvalid,
  output logic                          s_ipg_tready,
  input  logic                          ipg_enable,
  output logic [31:0]                   stat_ipg_inserted,
  output logic [$clog2(FIFO_DEPTH):0]   stat_fifo_level
);

  localparam logic [1:0] GUARD = GUARD_WORDS[1:0];

  logic                     idle_in;
  logic                     insert;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_push;
  logic [IPG_PAYLOAD_W-1:0] fifo_head;
  logic [1:0]               idle_run;
  logic [1:0]               idle_run_next;

  // Ready is held low during reset as well as when the buffer is full.
  assign s_ipg_tready = tx_rst_n && !fifo_full;
  assign fifo_push    = s_ipg_tvalid && s_ipg_tready;

  assign idle_in = is_idle_word(xgmii_txd_in, xgmii_txc_in);
  assign insert  = ipg_enable && !fifo_empty && idle_in && (idle_run >= GUARD);

  always_comb begin
    idle_run_next = 2'd0;
    if (idle_in) idle_run_next = (idle_run == 2'd3) ? 2'd3 : idle_run + 2'd1;
  end

  ipg_sync_fifo #(
    .WIDTH (IPG_PAYLOAD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (tx_clk),
    .rst_n     (tx_rst_n),
    .push      (fifo_push),
    .push_data (s_ipg_tdata),
    .pop       (insert),
    .data      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (stat_fifo_level)
  );

  // Eligibility uses the pre-update run length; an inserted word still counts as idle.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      xgmii_txd_out     <= XGMII_IDLE_WORD;
      xgmii_txc_out     <= 8'hFF;
      stat_ipg_inserted <= '0;
      idle_run          <= 2'd0;
    end else begin
      idle_run <= idle_run_next;
      if (insert) begin
        xgmii_txd_out <= {fifo_head, IPG_MARK};
        xgmii_txc_out <= 8'h01;
        if (stat_ipg_inserted != 32'hFFFF_FFFF) stat_ipg_inserted <= stat_ipg_inserted + 32'd1;
      end else begin
        xgmii_txd_out <= xgmii_txd_in;
        xgmii_txc_out <= xgmii_txc_in;
      end
    end
  end

endmodule

// File: tb/tb_ipg_xgmii_tx_insert.sv
// tb/tb_ipg_xgmii_tx_insert.sv - randomized scoreboard bench for ipg_xgmii_tx_insert
module tb_ipg_xgmii_tx_insert;

  localparam int         DEPTH = 4;
  localparam int         GUARD = 1;
  localparam logic [7:0] MARK  = 8'h5C;
  localparam logic [63:0] IDLE = {8{8'h07}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] txd_in = IDLE;
  logic [7:0]  txc_in = 8'hFF;
  logic [63:0] txd_out;
  logic [7:0]  txc_out;
  logic [55:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        ipg_enable = 1'b0;
  logic [31:0] stat_ins;
  logic [2:0]  stat_level;

  ipg_xgmii_tx_insert #(
    .FIFO_DEPTH  (DEPTH),
    .GUARD_WORDS (GUARD),
    .IPG_MARK    (MARK)
  ) dut (
    .tx_clk            (clk),
    .tx_rst_n          (rst_n),
    .xgmii_txd_in      (txd_in),
    .xgmii_txc_in      (txc_in),
    .xgmii_txd_out     (txd_out),
    .xgmii_txc_out     (txc_out),
    .s_ipg_tdata       (tdata),
    .s_ipg_tvalid      (tvalid),
    .s_ipg_tready      (tready),
    .ipg_enable        (ipg_enable),
    .stat_ipg_inserted (stat_ins),
    .stat_fifo_level   (stat_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] txd;
    logic [7:0]  txc;
    int          level;
    logic [31:0] stat;
  } exp_t;

  exp_t        exp_q[$];
  logic [55:0] m_fifo[$];
  logic [55:0] src_q[$];
  int          m_run;
  logic [31:0] m_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected word per driven cycle, compared just after the edge.
  exp_t e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("txd_out", txd_out, e.txd);
      chk("txc_out", {56'd0, txc_out}, {56'd0, e.txc});
      chk("fifo_level", {61'd0, stat_level}, 64'(e.level));
      chk("stat_inserted", {32'd0, stat_ins}, {32'd0, e.stat});
      chk("tready", {63'd0, tready}, {63'd0, (e.level < DEPTH)});
    end
  end

  // Drive one XGMII word (called at a negedge) and predict the next-cycle output.
  task automatic cycle(input logic [63:0] d, input logic [7:0] c);
    exp_t x;
    bit   idle, ins, ready;
    txd_in = d;
    txc_in = c;
    tvalid = (src_q.size() > 0);
    tdata  = tvalid ? src_q[0] : 56'({$urandom(), $urandom()});
    idle   = (c == 8'hFF) && (d == IDLE);
    ready  = (m_fifo.size() < DEPTH);
    ins    = ipg_enable && (m_fifo.size() > 0) && idle && (m_run >= GUARD);
    if (ins) begin
      x.txd = {m_fifo.pop_front(), MARK};
      x.txc = 8'h01;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else begin
      x.txd = d;
      x.txc = c;
    end
    m_run = idle ? ((m_run < 3) ? m_run + 1 : 3) : 0;
    if (tvalid && ready) m_fifo.push_back(src_q.pop_front());
    x.level = m_fifo.size();
    x.stat  = m_cnt;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) cycle(IDLE, 8'hFF);
  endtask

  task automatic send_frame();
    cycle({56'({$urandom(), $urandom()}), 8'hFB}, 8'h01);
    for (int i = 0; i < 7; i++) cycle({$urandom(), $urandom()}, 8'h00);
    cycle({24'h070707, 8'hFD, 32'($urandom())}, 8'hF0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    tvalid = 1'b0;
    #1;
    chk("rst_txd", txd_out, IDLE);
    chk("rst_txc", {56'd0, txc_out}, 64'hFF);
    chk("rst_level", {61'd0, stat_level}, 64'd0);
    chk("rst_stat", {32'd0, stat_ins}, 64'd0);
    chk("rst_tready", {63'd0, tready}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_fifo.delete();
    src_q.delete();
    exp_q.delete();
    m_run = 0;
    m_cnt = '0;
  endtask

  initial begin
    int r;
    @(negedge clk);
    do_reset();

    // Passthrough with insertion disabled, payload buffered.
    ipg_enable = 1'b0;
    src_q.push_back(56'h11223344556677);
    src_q.push_back(56'h8899AABBCCDDEE);
    send_frame();
    idles(4);

    // Single insert after a terminate word.
    do_reset();
    ipg_enable = 1'b1;
    src_q.push_back(56'hA1A2A3A4A5A6A7);
    cycle({24'h070707, 8'hFD, 32'hDEADBEEF}, 8'hF0);
    idles(3);

    // Five pushes against a depth-4 buffer, then a back-to-back drain.
    for (int i = 0; i < 5; i++) src_q.push_back(56'({$urandom(), $urandom()}));
    for (int i = 0; i < 6; i++) cycle({$urandom(), $urandom()}, 8'h00);
    idles(8);

    // Error control word resets the guard.
    ipg_enable = 1'b0;
    src_q.push_back(56'h0F0E0D0C0B0A09);
    src_q.push_back(56'h19181716151413);
    idles(3);
    ipg_enable = 1'b1;
    cycle({8{8'hFE}}, 8'hFF);
    idles(4);

    // Enable gating, then reset mid-stream discards the buffer.
    ipg_enable = 1'b0;
    src_q.push_back(56'h2A2B2C2D2E2F20);
    src_q.push_back(56'h3A3B3C3D3E3F30);
    idles(4);
    ipg_enable = 1'b1;
    send_frame();
    do_reset();
    idles(4);

    // Statistic saturation via backdoor preload.
    force dut.stat_ipg_inserted = 32'hFFFF_FFFE;
    #1;
    release dut.stat_ipg_inserted;
    m_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    for (int i = 0; i < 3; i++) src_q.push_back(56'({$urandom(), $urandom()}));
    idles(8);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) ipg_enable = ~ipg_enable;
      if ($urandom_range(0, 3) == 0 && src_q.size() < 8) src_q.push_back(56'({$urandom(), $urandom()}));
      r = $urandom_range(0, 99);
      if (r < 55)      cycle(IDLE, 8'hFF);
      else if (r < 62) cycle({IDLE[63:8], 8'h9C}, 8'hFF);
      else if (r < 70) cycle({8{8'hFE}}, 8'hFF);
      else if (r < 75) send_frame();
      else             cycle({$urandom(), $urandom()}, 8'h00);
    end
    idles(2);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
